// File: rtl/ask4_tx_source.sv
// ask4_tx_source: sample/symbol strobe generator and pseudo-random
// Gray-mapped 4-ASK symbol source (1s17) with frame marker for the MER path.
module ask4_tx_source #(
    parameter int                 SAM_DIV    = 4,
    parameter int                 SPS        = 4,
    parameter logic [21:0]        LFSR_SEED  = 22'h3FFFFF,
    parameter logic signed [17:0] LVL_IN     = 18'sd32768,
    parameter logic signed [17:0] LVL_OUT    = 18'sd98304,
    parameter int                 ZERO_STUFF = 1,
    parameter int                 FRAME_LOG2 = 20
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                run,
    input  logic [2:0]          scale,
    output logic                sam_clk_en,
    output logic                sym_clk_en,
    output logic signed [17:0]  x_out,
    output logic [1:0]          sym_bits,
    output logic                frame_start,
    output logic [21:0]         lfsr_state
);

    localparam int DIV_W = (SAM_DIV > 1) ? $clog2(SAM_DIV) : 1;
    localparam int PH_W  = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAM_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SPS - 1);

    logic [DIV_W-1:0]        r_div_cnt;
    logic [PH_W-1:0]         r_phase;
    logic [FRAME_LOG2-1:0]   r_sym_cnt;
    logic [21:0]             r_lfsr;
    logic [1:0]              r_sym_bits;
    logic signed [17:0]      r_x_p1;

    logic                    w_sam;
    logic                    w_sym;
    logic signed [17:0]      w_lvl_p0;

    // Gray map: adjacent levels differ in one bit
    function automatic logic signed [17:0] f_map(input logic [1:0] b);
        case (b)
            2'b00:   return -LVL_OUT;
            2'b01:   return -LVL_IN;
            2'b11:   return LVL_IN;
            default: return LVL_OUT;
        endcase
    endfunction

    // Level attenuation; the largest level already fits, so no clipping
    function automatic logic signed [17:0] f_scale(input logic signed [17:0] v,
                                                   input logic [2:0] s);
        return v >>> s;
    endfunction

    // Strobes are decoded from registered counters only, so they cannot glitch
    assign w_sam    = run && (r_div_cnt == DIV_LAST);
    assign w_sym    = w_sam && (r_phase == PH_LAST);
    assign w_lvl_p0 = f_scale(f_map(r_lfsr[1:0]), scale);

    // sys_clk divider producing the sample strobe
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (run) begin
            if (w_sam) r_div_cnt <= '0;
            else       r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Sample phase within the symbol
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (w_sam) begin
            if (w_sym) r_phase <= '0;
            else       r_phase <= r_phase + PH_W'(1);
        end
    end

    // Symbol counter for frame marking; wraps naturally at 2^FRAME_LOG2
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_sym_cnt <= '0;
        end else if (w_sym) begin
            r_sym_cnt <= r_sym_cnt + FRAME_LOG2'(1);
        end
    end

    // PRBS x^22+x^21+1, with recovery from the stuck all-zero state
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_sym) begin
            if (r_lfsr == '0) r_lfsr <= LFSR_SEED;
            else              r_lfsr <= {r_lfsr[20:0], r_lfsr[21] ^ r_lfsr[20]};
        end
    end

    // Symbol launch: capture raw bits and scaled level before the LFSR shifts
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_sym_bits <= '0;
            r_x_p1     <= '0;
        end else if (w_sam) begin
            if (w_sym) begin
                r_sym_bits <= r_lfsr[1:0];
                r_x_p1     <= w_lvl_p0;
            end else if (ZERO_STUFF != 0) begin
                r_x_p1     <= '0;
            end
        end
    end

    assign sam_clk_en  = w_sam;
    assign sym_clk_en  = w_sym;
    assign frame_start = w_sym && (&r_sym_cnt);
    assign x_out       = r_x_p1;
    assign sym_bits    = r_sym_bits;
    assign lfsr_state  = r_lfsr;

endmodule

// File: tb/tb_ask4_tx_source.sv
// Testbench for ask4_tx_source: three instances (default, hold-mode,
// short frame) driven in lock-step and compared to a cycle-count model.
module tb_ask4_tx_source;

    localparam int SAM_DIV = 4;
    localparam int SPS     = 4;
    localparam int P       = SAM_DIV * SPS;
    localparam logic [21:0] SEED = 22'h3FFFFF;

    logic clk = 1'b0;
    logic reset;
    logic run;
    logic [2:0] scale;

    logic a_sam, a_sym, a_fr; logic signed [17:0] a_x; logic [1:0] a_bits; logic [21:0] a_lfsr;
    logic b_sam, b_sym, b_fr; logic signed [17:0] b_x; logic [1:0] b_bits; logic [21:0] b_lfsr;
    logic c_sam, c_sym, c_fr; logic signed [17:0] c_x; logic [1:0] c_bits; logic [21:0] c_lfsr;

    ask4_tx_source dut (
        .sys_clk(clk), .reset(reset), .run(run), .scale(scale),
        .sam_clk_en(a_sam), .sym_clk_en(a_sym), .x_out(a_x),
        .sym_bits(a_bits), .frame_start(a_fr), .lfsr_state(a_lfsr));

    ask4_tx_source #(.ZERO_STUFF(0)) dut_hold (
        .sys_clk(clk), .reset(reset), .run(run), .scale(scale),
        .sam_clk_en(b_sam), .sym_clk_en(b_sym), .x_out(b_x),
        .sym_bits(b_bits), .frame_start(b_fr), .lfsr_state(b_lfsr));

    ask4_tx_source #(.FRAME_LOG2(4)) dut_f4 (
        .sys_clk(clk), .reset(reset), .run(run), .scale(scale),
        .sam_clk_en(c_sam), .sym_clk_en(c_sym), .x_out(c_x),
        .sym_bits(c_bits), .frame_start(c_fr), .lfsr_state(c_lfsr));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: n = number of run-enabled clock edges since reset.
    int n = 0;
    logic [21:0] seq [0:1023];   // LFSR contents after k symbols
    int          scl [0:1023];   // scale captured at the launch of symbol k (1-based)

    logic e_sam, e_sym, e_fr, e_fr4;
    logic signed [17:0] e_xz, e_xh;
    logic [1:0] e_bits;
    logic [21:0] e_lfsr;

    function automatic int lvl(input logic [1:0] b);
        case (b)
            2'b00:   return -98304;
            2'b01:   return -32768;
            2'b11:   return 32768;
            default: return 98304;
        endcase
    endfunction

    task automatic model_expect();
        int nsym, nsam, v;
        nsym = n / P;
        nsam = n / SAM_DIV;
        e_sam = run && !reset && (n % SAM_DIV == SAM_DIV - 1);
        e_sym = e_sam && (nsam % SPS == SPS - 1);
        e_lfsr = seq[nsym];
        if (nsym == 0) begin
            e_bits = 2'b00;
            v = 0;
        end else begin
            e_bits = seq[nsym-1][1:0];
            v = lvl(e_bits) >>> scl[nsym];
        end
        e_xh = 18'(v);
        e_xz = (nsym > 0 && nsam % SPS == 0) ? 18'(v) : 18'sd0;
        e_fr  = e_sym && (nsym % (1 << 20) == (1 << 20) - 1);
        e_fr4 = e_sym && (nsym % 16 == 15);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) n = 0;
        else if (run) begin
            if (n % P == P - 1) scl[n / P + 1] = scale;
            n++;
        end
        #1;
        model_expect();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        n     = 0;
        repeat (2) tick();
        reset = 1'b0;
        model_expect();
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; scale = 3'd0;
        #2;
        repeat (2) tick();
        checks++; if (a_sam !== 1'b0) begin errors++; $display("FAIL reset_sam: got %0b want 0", a_sam); end
        checks++; if (a_sym !== 1'b0) begin errors++; $display("FAIL reset_sym: got %0b want 0", a_sym); end
        checks++; if (a_x !== 18'sd0) begin errors++; $display("FAIL reset_x: got %0d want 0", a_x); end
        checks++; if (a_bits !== 2'b00) begin errors++; $display("FAIL reset_bits: got %0b want 00", a_bits); end
        checks++; if (a_fr !== 1'b0 || c_fr !== 1'b0) begin errors++; $display("FAIL reset_frame: got %0b/%0b want 0", a_fr, c_fr); end
        checks++; if (a_lfsr !== SEED) begin errors++; $display("FAIL reset_lfsr: got %h want %h", a_lfsr, SEED); end
        checks++; if (b_x !== 18'sd0) begin errors++; $display("FAIL reset_hold_x: got %0d want 0", b_x); end
    endtask

    task automatic test_strobe_timing();
        int first_sam, first_sym;
        logic prev_sam, prev_sym;
        logic signed [17:0] xs [0:3];
        do_reset();
        run = 1'b1; scale = 3'd0;
        first_sam = 0; first_sym = 0; prev_sam = 1'b0; prev_sym = 1'b0;
        checks++; if (a_sam !== 1'b0) begin errors++; $display("FAIL release_sam: got %0b want 0", a_sam); end
        for (int j = 1; j <= 64; j++) begin
            tick();
            checks++; if (a_sam !== e_sam) begin errors++; $display("FAIL timing_sam n=%0d: got %0b want %0b", n, a_sam, e_sam); end
            checks++; if (a_sym !== e_sym) begin errors++; $display("FAIL timing_sym n=%0d: got %0b want %0b", n, a_sym, e_sym); end
            checks++; if (a_x !== e_xz) begin errors++; $display("FAIL timing_x n=%0d: got %0d want %0d", n, a_x, e_xz); end
            checks++; if ((a_sam && prev_sam) || (a_sym && prev_sym)) begin errors++; $display("FAIL strobe_width n=%0d: sam %0b%0b sym %0b%0b", n, prev_sam, a_sam, prev_sym, a_sym); end
            if (a_sam === 1'b1 && first_sam == 0) first_sam = j + 1;
            if (a_sym === 1'b1 && first_sym == 0) first_sym = j + 1;
            if (n % P == 0 && n / P <= 4) xs[n / P - 1] = a_x;
            prev_sam = a_sam; prev_sym = a_sym;
        end
        checks++; if (first_sam != 4) begin errors++; $display("FAIL first_sam_cycle: got %0d want 4", first_sam); end
        checks++; if (first_sym != 16) begin errors++; $display("FAIL first_sym_cycle: got %0d want 16", first_sym); end
        checks++; if (xs[0] !== 18'sd32768) begin errors++; $display("FAIL sym1_x: got %0d want 32768", xs[0]); end
        checks++; if (xs[1] !== 18'sd98304) begin errors++; $display("FAIL sym2_x: got %0d want 98304", xs[1]); end
        checks++; if (xs[2] !== -18'sd98304) begin errors++; $display("FAIL sym3_x: got %0d want -98304", xs[2]); end
    endtask

    task automatic test_scale();
        logic signed [17:0] xs [0:3];
        do_reset();
        run = 1'b1; scale = 3'd2;
        for (int j = 1; j <= 48; j++) begin
            tick();
            if (n % P == 0) xs[n / P - 1] = a_x;
            checks++; if (a_x !== e_xz) begin errors++; $display("FAIL scale2_x n=%0d: got %0d want %0d", n, a_x, e_xz); end
        end
        checks++; if (xs[0] !== 18'sd8192) begin errors++; $display("FAIL scale2_sym11: got %0d want 8192", xs[0]); end
        checks++; if (xs[1] !== 18'sd24576) begin errors++; $display("FAIL scale2_sym10: got %0d want 24576", xs[1]); end
        checks++; if (xs[2] !== -18'sd24576) begin errors++; $display("FAIL scale2_sym00: got %0d want -24576", xs[2]); end
        // Scale changes at a random point inside each symbol
        for (int s = 0; s < 24; s++) begin
            int at;
            at = $urandom_range(0, P - 1);
            for (int k = 0; k < P; k++) begin
                if (k == at) scale = 3'($urandom_range(0, 7));
                tick();
                checks++; if (a_x !== e_xz || b_x !== e_xh) begin errors++; $display("FAIL scale_mid n=%0d: got %0d/%0d want %0d/%0d", n, a_x, b_x, e_xz, e_xh); end
                checks++; if (a_bits !== e_bits) begin errors++; $display("FAIL scale_bits n=%0d: got %0b want %0b", n, a_bits, e_bits); end
            end
        end
    endtask

    task automatic test_run_pause();
        run = 1'b1;
        repeat (7) tick();
        run = 1'b0;
        for (int j = 0; j < 37 + 100; j++) begin
            if (j == 37) run = 1'b1;
            tick();
            checks++; if (a_sam !== e_sam || a_sym !== e_sym) begin errors++; $display("FAIL pause_strobe n=%0d: got %0b%0b want %0b%0b", n, a_sam, a_sym, e_sam, e_sym); end
            checks++; if (a_x !== e_xz || b_x !== e_xh) begin errors++; $display("FAIL pause_x n=%0d: got %0d/%0d want %0d/%0d", n, a_x, b_x, e_xz, e_xh); end
            checks++; if (a_lfsr !== e_lfsr || a_bits !== e_bits) begin errors++; $display("FAIL pause_state n=%0d: got %h/%0b want %h/%0b", n, a_lfsr, a_bits, e_lfsr, e_bits); end
        end
        for (int j = 0; j < 300; j++) begin
            run = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) scale = 3'($urandom_range(0, 7));
            tick();
            checks++; if (a_sam !== e_sam || a_sym !== e_sym || b_sam !== e_sam) begin errors++; $display("FAIL rand_strobe n=%0d: got %0b%0b want %0b%0b", n, a_sam, a_sym, e_sam, e_sym); end
            checks++; if (a_x !== e_xz || b_x !== e_xh || b_bits !== e_bits) begin errors++; $display("FAIL rand_x n=%0d: got %0d/%0d want %0d/%0d", n, a_x, b_x, e_xz, e_xh); end
            checks++; if (b_lfsr !== e_lfsr) begin errors++; $display("FAIL rand_lfsr n=%0d: got %h want %h", n, b_lfsr, e_lfsr); end
        end
    endtask

    task automatic test_frame();
        int first, cnt;
        do_reset();
        run = 1'b1; scale = 3'($urandom_range(0, 7));
        first = 0; cnt = 0;
        for (int j = 1; j <= 800; j++) begin
            tick();
            checks++; if (c_fr !== e_fr4) begin errors++; $display("FAIL frame4 n=%0d: got %0b want %0b", n, c_fr, e_fr4); end
            checks++; if (a_fr !== e_fr) begin errors++; $display("FAIL frame20 n=%0d: got %0b want %0b", n, a_fr, e_fr); end
            checks++; if (c_x !== e_xz) begin errors++; $display("FAIL frame4_x n=%0d: got %0d want %0d", n, c_x, e_xz); end
            if (c_fr === 1'b1) begin
                cnt++;
                if (first == 0) first = j;
            end
        end
        checks++; if (first != 255) begin errors++; $display("FAIL frame_first: got edge %0d want 255", first); end
        checks++; if (cnt != 3) begin errors++; $display("FAIL frame_count: got %0d want 3", cnt); end
    endtask

    task automatic test_async_reset();
        logic signed [17:0] xs [0:3];
        run = 1'b1;
        for (int j = 0; j < 100; j++) begin
            if (j % 9 == 0) scale = 3'($urandom_range(0, 7));
            tick();
        end
        #3;
        reset = 1'b1;
        n = 0;
        #1;
        model_expect();
        checks++; if (a_lfsr !== SEED || c_lfsr !== SEED) begin errors++; $display("FAIL async_lfsr: got %h want %h", a_lfsr, SEED); end
        checks++; if (a_x !== 18'sd0 || b_x !== 18'sd0 || a_bits !== 2'b00) begin errors++; $display("FAIL async_data: got %0d/%0d/%0b want 0", a_x, b_x, a_bits); end
        checks++; if (a_sam !== 1'b0 || a_sym !== 1'b0 || c_fr !== 1'b0) begin errors++; $display("FAIL async_strobe: got %0b%0b%0b want 000", a_sam, a_sym, c_fr); end
        repeat (2) tick();
        reset = 1'b0;
        scale = 3'd0;
        model_expect();
        checks++; if (a_sam !== 1'b0) begin errors++; $display("FAIL async_release_sam: got %0b want 0", a_sam); end
        for (int j = 1; j <= 48; j++) begin
            tick();
            if (n % P == 0) xs[n / P - 1] = a_x;
            checks++; if (a_sam !== e_sam || a_sym !== e_sym || a_x !== e_xz || a_lfsr !== e_lfsr) begin errors++; $display("FAIL post_reset n=%0d: got %0b%0b %0d %h want %0b%0b %0d %h", n, a_sam, a_sym, a_x, a_lfsr, e_sam, e_sym, e_xz, e_lfsr); end
        end
        checks++; if (xs[0] !== 18'sd32768 || xs[1] !== 18'sd98304 || xs[2] !== -18'sd98304) begin errors++; $display("FAIL post_reset_syms: got %0d %0d %0d want 32768 98304 -98304", xs[0], xs[1], xs[2]); end
    endtask

    initial begin
        seq[0] = SEED;
        for (int k = 1; k < 1024; k++) begin
            logic [21:0] s;
            s = seq[k-1];
            seq[k] = (s == 22'd0) ? SEED : {s[20:0], s[21] ^ s[20]};
        end
        for (int k = 0; k < 1024; k++) scl[k] = 0;

        test_reset();
        test_strobe_timing();
        test_scale();
        test_run_pause();
        test_frame();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ask4_tx_source.md
Name: ask4_tx_source

Overview:
Transmit-side stimulus source for the 4-ASK link. It generates the sample and symbol clock enables from sys_clk. It produces a pseudo-random Gray-mapped 4-ASK symbol stream in 1s17, upsampled to the sample rate, to drive the pulse-shaping filter. It also emits a frame marker every 2^20 symbols so the receive-side MER accumulators can be cleared in lock-step with the data.

Parameters:
SAM_DIV, 4, sys_clk cycles per sample (>=2)
SPS, 4, samples per symbol (>=2)
LFSR_SEED, 22'h3FFFFF, LFSR reset value (must be nonzero)
LVL_IN, 18'sd32768, inner level magnitude a (0.25 in 1s17)
LVL_OUT, 18'sd98304, outer level magnitude 3a (0.75 in 1s17)
ZERO_STUFF, 1, 1 = zero-insert between symbols; 0 = hold symbol for SPS samples
FRAME_LOG2, 20, frame length = 2^FRAME_LOG2 symbols

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  1 = generate; 0 = freeze all counters, LFSR and outputs
scale  in  3  arithmetic right shift applied to mapped level (0..7)
sam_clk_en  out  1  one-cycle sample strobe
sym_clk_en  out  1  one-cycle symbol strobe, always coincident with a sam_clk_en
x_out  out  18  signed 1s17 filter input, changes only on sam_clk_en edges
sym_bits  out  2  raw 2-bit symbol currently on air
frame_start  out  1  one-cycle pulse at the last symbol of each frame
lfsr_state  out  22  current LFSR contents (debug)

Behaviour:
- Reset (async, reset=1): div_cnt=0, phase=0, sym_cnt=0, lfsr=LFSR_SEED; all outputs 0 except lfsr_state=LFSR_SEED.
- div_cnt counts 0..SAM_DIV-1 while run=1 and wraps.
  - sam_clk_en = run && div_cnt==SAM_DIV-1 (combinational from registers, glitch-free).
  - First sam_clk_en occurs on the SAM_DIV-th cycle after reset release with run=1.
- phase counts 0..SPS-1 and advances on sam_clk_en.
  - sym_clk_en = sam_clk_en && phase==SPS-1.
- LFSR: Fibonacci, x^22+x^21+1. On sym_clk_en, lfsr <= {lfsr[20:0], lfsr[21]^lfsr[20]}.
  - If lfsr ever reads all-zero, it loads LFSR_SEED on the next sym_clk_en.
- On sym_clk_en, sym_bits <= lfsr[1:0], taken before the shift.
- Gray map: 00 -> -LVL_OUT, 01 -> -LVL_IN, 11 -> +LVL_IN, 10 -> +LVL_OUT.
  - The mapped value is arithmetically shifted right by scale, sampled at the same edge.
  - No saturation needed; the result is always within 18 bits.
- x_out on sam_clk_en:
  - If sym_clk_en: x_out <= scaled mapped level.
  - Else if ZERO_STUFF: x_out <= 0.
  - Else: hold.
- x_out latency: new symbol appears 1 cycle after the sym_clk_en edge and is valid for one full sample period.
- sym_cnt (FRAME_LOG2 bits) increments on sym_clk_en and wraps.
  - frame_start = sym_clk_en && sym_cnt==all-ones.
- run deasserted mid-symbol: all state holds; strobes stay low; resumes exactly where it stopped.
- scale changed mid-symbol: takes effect at the next sym_clk_en only.
- Reset mid-operation: immediate return to reset values. No partial strobe is emitted on the release cycle.

Test Plan:
- Reset release, run=1, defaults: sam_clk_en high on cycles 4, 8, 12…; sym_clk_en high on cycles 16, 32…; strobe widths exactly 1 cycle.
- Default seed, scale=0, ZERO_STUFF=1:
  - First three symbols on x_out are +32768, +98304, -98304 (LFSR 3FFFFF -> 3FFFFE -> 3FFFFC).
  - The next 3 samples after each symbol are 0.
- scale=2 with symbol 10: x_out=+24576; with 00: x_out=-24576. Changing scale mid-symbol alters only the following symbol.
- ZERO_STUFF=0: x_out holds each level for SPS sample strobes. run=0 for 37 cycles mid-symbol: no strobes; after resume, sequence is identical to an uninterrupted reference model shifted by 37 cycles.
- FRAME_LOG2 overridden to 4: frame_start pulses coincident with every 16th sym_clk_en, first at the 16th symbol.
- Async reset asserted between clock edges: outputs clear without a clock edge. Post-release sequence matches the fresh-reset sequence bit-exactly.
